// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count constants, decrypt FSM encoding and the inverse S-box,
// which key expansion and reference models also reuse.
package aes_pkg;

    localparam int unsigned DATA_WIDTH = 128;
    localparam int unsigned NR_AES128  = 10;
    localparam int unsigned NR_AES192  = 12;
    localparam int unsigned NR_AES256  = 14;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_ROUND = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] st_in,
    input  logic [DATA_WIDTH-1:0] round_key,
    input  logic                  last,
    output logic [DATA_WIDTH-1:0] st_out
);

    logic [DATA_WIDTH-1:0] ark;
    logic [DATA_WIDTH-1:0] mix;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    // Byte (r,c) sits at bits 127-8*(4c+r); row r rotates right by r columns.
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127-8*(4*c+r) -: 8] = INV_SBOX[st_in[127-8*(4*((c+4-r)%4)+r) -: 8]]
                                          ^ round_key[127-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    assign st_out = last ? ark : mix;

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher: one round per cycle in which round_key_rdy is high,
// round keys requested from NR down to 0.
module aes_decrypt #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NR         = 14
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] round_key,
    input  logic                  round_key_rdy,
    output logic [3:0]            round_key_addr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);
    import aes_pkg::*;

    localparam logic [3:0] NR_ADDR = 4'(NR);

    logic [2:0]            fsm_q, fsm_d;
    logic [3:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] st_q, st_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] round_out;
    logic                  last;

    assign last = (fsm_q == ST_FINAL);

    aes_inv_round u_inv_round (
        .st_in    (st_q),
        .round_key(round_key),
        .last     (last),
        .st_out   (round_out)
    );

    always_comb begin
        fsm_d  = fsm_q;
        addr_d = addr_q;
        st_d   = st_q;
        out_d  = out_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    st_d   = data_in;
                    addr_d = NR_ADDR;
                    fsm_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                if (round_key_rdy) begin
                    st_d   = st_q ^ round_key;
                    addr_d = NR_ADDR - 4'd1;
                    fsm_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_key_rdy) begin
                    st_d   = round_out;
                    addr_d = addr_q - 4'd1;
                    if (addr_q == 4'd1) begin
                        fsm_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                // Leave addr at NR so the first key of the next block is already presented.
                if (round_key_rdy) begin
                    out_d  = round_out;
                    addr_d = NR_ADDR;
                    fsm_d  = ST_DONE;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                addr_d = NR_ADDR;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fsm_q  <= ST_IDLE;
            addr_q <= NR_ADDR;
            st_q   <= '0;
            out_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            addr_q <= addr_d;
            st_q   <= st_d;
            out_q  <= out_d;
        end
    end

    assign round_key_addr = addr_q;
    assign busy           = (fsm_q == ST_INIT) || (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
    assign done           = (fsm_q == ST_DONE);
    assign data_out       = out_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 C.1 (NR=10) and C.3 (NR=14) vectors with round keys
// expanded locally, plus stalls, ignored starts, back-to-back blocks and reset.
module tb_aes_decrypt;
    import aes_pkg::*;

    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         start_v [2];
    logic [127:0] din_v   [2];
    logic [127:0] rk_v    [2];
    logic         rdy_v   [2];
    logic [3:0]   addr_v  [2];
    logic         busy_v  [2];
    logic         done_v  [2];
    logic [127:0] dout_v  [2];
    logic [127:0] keys    [2][16];
    logic [7:0]   sbox    [256];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 Clk = ~Clk;

    aes_decrypt #(.DATA_WIDTH(128), .NR(NR_AES256)) u_dut256 (
        .Clk(Clk), .Rst(Rst), .start(start_v[0]), .data_in(din_v[0]), .round_key(rk_v[0]),
        .round_key_rdy(rdy_v[0]), .round_key_addr(addr_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .data_out(dout_v[0])
    );

    aes_decrypt #(.DATA_WIDTH(128), .NR(NR_AES128)) u_dut128 (
        .Clk(Clk), .Rst(Rst), .start(start_v[1]), .data_in(din_v[1]), .round_key(rk_v[1]),
        .round_key_rdy(rdy_v[1]), .round_key_addr(addr_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .data_out(dout_v[1])
    );

    // Key store: the key for the requested index is presented in the same cycle.
    always_comb begin
        rk_v[0] = keys[0][addr_v[0]];
        rk_v[1] = keys[1][addr_v[1]];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic expand_key(input int which, input logic [255:0] key, input int nk,
                              input int nr);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++) begin
            keys[which][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // Issue one block from IDLE/DONE and follow it to DONE; inj_a/inj_b give the round index at
    // which a spurious start is pulsed while busy.
    task automatic run_block(input int which, input logic [127:0] ct, input bit stall,
                             input int inj_a, input int inj_b, input string tag);
        int   nr;
        int   k;
        int   cycles;
        int   stalls;
        int   addr_bad;
        logic r;
        nr = (which == 0) ? 14 : 10;
        din_v[which]   = ct;
        start_v[which] = 1'b1;
        rdy_v[which]   = 1'b1;
        @(posedge Clk); #1;
        start_v[which] = 1'b0;
        check_eq({tag, "_accept"}, {126'h0, busy_v[which], done_v[which]}, 128'h2);
        k = 0;
        cycles = 1;
        stalls = 0;
        addr_bad = 0;
        while (!done_v[which] && cycles < 200) begin
            if (addr_v[which] != 4'(nr - k)) addr_bad++;
            r = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
            rdy_v[which] = r;
            if (!r) stalls++;
            start_v[which] = (k == inj_a) || (k == inj_b);
            din_v[which]   = start_v[which] ? ~ct : ct;
            @(posedge Clk); #1;
            if (r) k++;
            cycles++;
        end
        start_v[which] = 1'b0;
        din_v[which]   = ct;
        rdy_v[which]   = 1'b1;
        check_eq({tag, "_done"}, {127'h0, done_v[which]}, 128'h1);
        check_eq({tag, "_plaintext"}, dout_v[which], PT);
        check_eq({tag, "_latency"}, 128'(cycles), 128'(nr + 2 + stalls));
        check_eq({tag, "_addr_seq_errs"}, 128'(addr_bad), 128'h0);
        check_eq({tag, "_done_state"}, {123'h0, busy_v[which], addr_v[which]}, 128'(nr));
    endtask

    initial begin
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            rdy_v[i]   = 1'b1;
            din_v[i]   = '0;
        end
        for (int i = 0; i < 256; i++) sbox[INV_SBOX[i]] = 8'(i);
        expand_key(0, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   8, 14);
        expand_key(1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);

        // Asynchronous reset, observed before the first clock edge.
        #2 Rst = 1'b0;
        #1;
        check_eq("reset_busy", {126'h0, busy_v[0], busy_v[1]}, 128'h0);
        check_eq("reset_done", {126'h0, done_v[0], done_v[1]}, 128'h0);
        check_eq("reset_addr", {120'h0, addr_v[0], addr_v[1]}, 128'hea);
        check_eq("reset_data_out", dout_v[0] | dout_v[1], 128'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst = 1'b1;
        @(posedge Clk); #1;

        run_block(0, CT256, 1'b0, -1, -1, "c3");
        run_block(0, CT256, 1'b1, -1, -1, "c3_stall");
        run_block(1, CT128, 1'b0, -1, -1, "c1");
        run_block(0, CT256, 1'b0, 3, 9, "c3_inject");
        run_block(0, CT256, 1'b0, -1, -1, "c3_b2b");
        run_block(1, CT128, 1'b1, -1, -1, "c1_stall");

        // Abort a block mid-flight with reset, then run a fresh block.
        din_v[0]   = CT256;
        start_v[0] = 1'b1;
        @(posedge Clk); #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 50 && addr_v[0] != 4'd7; i++) begin
            @(posedge Clk); #1;
        end
        check_eq("abort_reached_addr7", {124'h0, addr_v[0]}, 128'h7);
        #3 Rst = 1'b0;
        #1;
        check_eq("abort_busy", {127'h0, busy_v[0]}, 128'h0);
        check_eq("abort_done", {127'h0, done_v[0]}, 128'h0);
        check_eq("abort_addr", {124'h0, addr_v[0]}, 128'he);
        check_eq("abort_data_out", dout_v[0], 128'h0);
        @(posedge Clk);
        @(negedge Clk) Rst = 1'b1;
        @(posedge Clk); #1;
        check_eq("abort_idle_busy", {127'h0, busy_v[0]}, 128'h0);
        run_block(0, CT256, 1'b0, -1, -1, "c3_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
